// File: rtl/rst_cipher_pkg.sv
// Shared types for the rst_cipher pipeline: the ciphertext pair layout,
// the NUL marker that flags an invalid cipher input, and the serializer states.
package rst_cipher_pkg;

    localparam logic [7:0] NUL_CHAR = 8'h00;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } ctxt_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HI,
        SEND_LO
    } ser_state_t;

endpackage

// File: rtl/rst_sync_fifo.sv
// Synchronous FIFO with occupancy count. Full and empty come from the count,
// so pointer equality is never ambiguous. The head and the entry behind it
// are both visible, which lets a consumer chain pops without a bubble.
module rst_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_din,
    output logic [DATA_W-1:0]        o_head,
    output logic [DATA_W-1:0]        o_head_next,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AW-1:0]     w_rd_next;
    logic              w_do_pop;
    logic              w_do_push;

    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign w_rd_next   = r_rd_ptr + 1'b1;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_head_next = r_mem[w_rd_next];
    assign w_do_pop    = i_pop && !o_empty;
    assign w_do_push   = i_push && (!o_full || w_do_pop);

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and count; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= w_rd_next;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rst_ctxt_serializer.sv
// Buffers ciphertext pairs from rst_cipher and streams them out as bytes,
// row char then column char, under a valid/ready handshake. NUL pairs are
// dropped and counted; pairs lost to a full buffer raise a sticky flag.
module rst_ctxt_serializer
    import rst_cipher_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter bit DROP_NUL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [15:0]            ctxt_str,
    input  logic                   ctxt_ready,
    output logic [7:0]             out_char,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_overflow,
    output logic [7:0]             nul_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    ser_state_t r_state;
    logic [7:0] r_out_char;
    logic       r_out_valid;
    logic       r_err_overflow;
    logic [7:0] r_nul_count;

    ctxt_pair_t w_in_pair;
    ctxt_pair_t w_head;
    ctxt_pair_t w_head_next;
    logic       w_full;
    logic       w_empty;
    logic       w_is_nul;
    logic       w_xfer;
    logic       w_pop;
    logic       w_push;
    logic       w_lost;

    assign w_in_pair = ctxt_pair_t'(ctxt_str);
    assign w_is_nul  = DROP_NUL && (w_in_pair.row == NUL_CHAR) && (w_in_pair.col == NUL_CHAR);
    assign w_xfer    = r_out_valid && out_ready;
    // The head retires when its column char is accepted.
    assign w_pop     = (r_state == SEND_LO) && w_xfer;
    // A retiring head frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_push    = ctxt_ready && !w_is_nul && !clear && (!w_full || w_pop);
    assign w_lost    = ctxt_ready && !w_is_nul && !clear && w_full && !w_pop;

    rst_sync_fifo #(
        .DATA_W (16),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (clear),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_din       (ctxt_str),
        .o_head      (w_head),
        .o_head_next (w_head_next),
        .o_count     (fifo_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Output FSM: walks each head pair through row then column byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_char  <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_out_char  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_out_char  <= w_head.row;
                        r_out_valid <= 1'b1;
                        r_state     <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (w_xfer) begin
                        r_out_char <= w_head.col;
                        r_state    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (w_xfer) begin
                        if (fifo_count > CNT_ONE) begin
                            r_out_char <= w_head_next.row;
                            r_state    <= SEND_HI;
                        end else if (w_push) begin
                            // Only pair left is the one arriving now; bypass it.
                            r_out_char <= w_in_pair.row;
                            r_state    <= SEND_HI;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag: set when a real pair is lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
        end else if (clear) begin
            r_err_overflow <= 1'b0;
        end else if (w_lost) begin
            r_err_overflow <= 1'b1;
        end
    end

    // Saturating count of dropped NUL pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nul_count <= 8'h00;
        end else if (clear) begin
            r_nul_count <= 8'h00;
        end else if (ctxt_ready && w_is_nul && (r_nul_count != 8'hFF)) begin
            r_nul_count <= r_nul_count + 8'h01;
        end
    end

    assign out_char     = r_out_char;
    assign out_valid    = r_out_valid;
    assign err_overflow = r_err_overflow;
    assign nul_count    = r_nul_count;

endmodule

// File: tb/tb_rst_ctxt_serializer.sv
// Directed bench for rst_ctxt_serializer (DEPTH=8, DROP_NUL=1).
module tb_rst_ctxt_serializer;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [15:0] ctxt_str;
    logic        ctxt_ready;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_count;
    logic        err_overflow;
    logic [7:0]  nul_count;

    int n_chk;
    int n_pass;
    logic [7:0] mon_q [$];
    logic [7:0] exp_q [$];

    rst_ctxt_serializer #(
        .DEPTH    (8),
        .DROP_NUL (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .ctxt_str     (ctxt_str),
        .ctxt_ready   (ctxt_ready),
        .out_char     (out_char),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .err_overflow (err_overflow),
        .nul_count    (nul_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte that transfers at the following rising edge.
    always @(negedge clk) begin
        if (!rst && !clear && out_valid && out_ready) mon_q.push_back(out_char);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 16'(mon_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < mon_q.size()) check($sformatf("%s_b%0d", tag, i), {8'h00, mon_q[i]}, {8'h00, exp_q[i]});
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        clear = 1'b0;
        ctxt_str = 16'h0000;
        ctxt_ready = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid", {15'd0, out_valid}, 16'd0);
        check("rst_char", {8'd0, out_char}, 16'd0);
        check("rst_count", {12'd0, fifo_count}, 16'd0);
        check("rst_ovf", {15'd0, err_overflow}, 16'd0);
        check("rst_nul", {8'd0, nul_count}, 16'd0);
        rst = 1'b0;
        step();

        // Single pair, latency and byte order.
        out_ready = 1'b1;
        ctxt_str = 16'h6162;
        ctxt_ready = 1'b1;
        step();
        ctxt_ready = 1'b0;
        check("single_valid0", {15'd0, out_valid}, 16'd0);
        check("single_cnt1", {12'd0, fifo_count}, 16'd1);
        step();
        check("single_valid1", {15'd0, out_valid}, 16'd1);
        check("single_hi", {8'd0, out_char}, 16'h0061);
        step();
        check("single_lo", {8'd0, out_char}, 16'h0062);
        check("single_lo_vld", {15'd0, out_valid}, 16'd1);
        step();
        check("single_idle_vld", {15'd0, out_valid}, 16'd0);
        check("single_cnt0", {12'd0, fifo_count}, 16'd0);

        // Back-pressure holds the row byte stable.
        out_ready = 1'b0;
        ctxt_str = 16'h6162;
        ctxt_ready = 1'b1;
        step();
        ctxt_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_vld%0d", i), {15'd0, out_valid}, 16'd1);
            check($sformatf("bp_chr%0d", i), {8'd0, out_char}, 16'h0061);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_lo", {8'd0, out_char}, 16'h0062);
        step();
        check("bp_done", {15'd0, out_valid}, 16'd0);
        check("bp_cnt0", {12'd0, fifo_count}, 16'd0);

        // Burst of 10 into DEPTH=8: last two lost, first eight drained in order.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ctxt_str = {8'h61, 8'(8'h30 + i)};
            ctxt_ready = 1'b1;
            step();
        end
        ctxt_ready = 1'b0;
        check("burst_cnt", {12'd0, fifo_count}, 16'd8);
        check("burst_ovf", {15'd0, err_overflow}, 16'd1);
        mon_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h61);
            exp_q.push_back(8'(8'h30 + i));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) step();
        compare_stream("burst");
        check("burst_cnt0", {12'd0, fifo_count}, 16'd0);
        check("burst_ovf_sticky", {15'd0, err_overflow}, 16'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("burst_ovf_clr", {15'd0, err_overflow}, 16'd0);

        // Full FIFO accepts a pair when the head retires in the same cycle.
        out_ready = 1'b0;
        mon_q.delete();
        for (int i = 0; i < 8; i++) begin
            ctxt_str = {8'h62, 8'(8'h30 + i)};
            ctxt_ready = 1'b1;
            step();
        end
        ctxt_ready = 1'b0;
        check("fr_full", {12'd0, fifo_count}, 16'd8);
        out_ready = 1'b1;
        step();
        check("fr_in_lo", {8'd0, out_char}, 16'h0030);
        ctxt_str = 16'h6378;
        ctxt_ready = 1'b1;
        step();
        ctxt_ready = 1'b0;
        check("fr_cnt", {12'd0, fifo_count}, 16'd8);
        check("fr_ovf", {15'd0, err_overflow}, 16'd0);
        check("fr_next", {8'd0, out_char}, 16'h0062);
        for (int i = 0; i < 24; i++) step();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h62);
            exp_q.push_back(8'(8'h30 + i));
        end
        exp_q.push_back(8'h63);
        exp_q.push_back(8'h78);
        compare_stream("fr");

        // NUL pairs are dropped and counted.
        mon_q.delete();
        out_ready = 1'b1;
        ctxt_ready = 1'b1;
        ctxt_str = 16'h0000;
        step();
        ctxt_str = 16'h6364;
        step();
        ctxt_str = 16'h0000;
        step();
        step();
        ctxt_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        exp_q.delete();
        exp_q.push_back(8'h63);
        exp_q.push_back(8'h64);
        compare_stream("nul");
        check("nul_cnt3", {8'd0, nul_count}, 16'd3);
        ctxt_str = 16'h0000;
        ctxt_ready = 1'b1;
        for (int i = 0; i < 300; i++) step();
        ctxt_ready = 1'b0;
        check("nul_sat", {8'd0, nul_count}, 16'd255);
        check("nul_fifo", {12'd0, fifo_count}, 16'd0);
        check("nul_ovf", {15'd0, err_overflow}, 16'd0);

        // Asynchronous reset between edges with pairs buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ctxt_str = {8'h64, 8'(8'h30 + i)};
            ctxt_ready = 1'b1;
            step();
        end
        ctxt_ready = 1'b0;
        step();
        check("ar_pre_cnt", {12'd0, fifo_count}, 16'd4);
        check("ar_pre_vld", {15'd0, out_valid}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_vld", {15'd0, out_valid}, 16'd0);
        check("ar_chr", {8'd0, out_char}, 16'd0);
        check("ar_cnt", {12'd0, fifo_count}, 16'd0);
        check("ar_nul", {8'd0, nul_count}, 16'd0);
        step();
        rst = 1'b0;
        step();

        // Clear together with ctxt_ready discards the incoming pair.
        for (int i = 0; i < 2; i++) begin
            ctxt_str = {8'h65, 8'(8'h30 + i)};
            ctxt_ready = 1'b1;
            step();
        end
        ctxt_ready = 1'b0;
        step();
        check("clr_pre_vld", {15'd0, out_valid}, 16'd1);
        clear = 1'b1;
        ctxt_str = 16'h6566;
        ctxt_ready = 1'b1;
        step();
        clear = 1'b0;
        ctxt_ready = 1'b0;
        check("clr_cnt", {12'd0, fifo_count}, 16'd0);
        check("clr_vld", {15'd0, out_valid}, 16'd0);
        step();
        check("clr_cnt_after", {12'd0, fifo_count}, 16'd0);
        check("clr_vld_after", {15'd0, out_valid}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rst_ctxt_serializer.md
Name: rst_ctxt_serializer

Overview:
- Downstream stage of rst_cipher. Captures each 16-bit ciphertext pair (row char in [15:8], column char in [7:0]) in the cycle rst_cipher asserts ctxt_ready.
- Buffers pairs in a small FIFO and emits them as a byte stream under a valid/ready handshake: row char first, then column char.
- Isolates the cipher, which has no back-pressure, from a stalling sink (UART or file writer).
- Drops all-NUL pairs, which are rst_cipher's invalid-input result, and counts them.

Parameters:
- DEPTH, 8, FIFO entries in 16-bit pairs; power of 2, at least 2.
- DROP_NUL, 1, when 1 a pair equal to 16'h0000 is not stored and increments nul_count; when 0 it is stored like any other pair.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous flush of the FIFO, FSM, flags and counter.
- ctxt_str  in  16  ciphertext pair from rst_cipher.
- ctxt_ready  in  1  ctxt_str is valid this cycle; single-cycle qualifier, no back-pressure possible.
- out_char  out  8  output byte.
- out_valid  out  1  out_char is valid.
- out_ready  in  1  sink accepts out_char this cycle.
- fifo_count  out  $clog2(DEPTH)+1  pairs held, including the pair being sent.
- err_overflow  out  1  sticky: a pair arrived while the FIFO was full.
- nul_count  out  8  saturating count of dropped NUL pairs.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, all outputs are 0: out_char=8'h00, out_valid=0, fifo_count=0, err_overflow=0, nul_count=0, FSM=IDLE.
- Priority of events: rst, then clear, then normal operation.
- clear=1: at the edge, the FIFO empties, FSM goes to IDLE, out_valid=0, and both flags/counters reset. A ctxt_ready in the same cycle is discarded.
- Write condition: a write occurs when ctxt_ready=1, the pair is not NUL-dropped, and either fifo_count<DEPTH or the head pair retires in the same cycle.
- Full FIFO: if the write condition fails only because the FIFO is full, the pair is lost and err_overflow is set to 1. err_overflow stays at 1 until clear or rst.
- NUL pairs: a NUL pair with DROP_NUL=1 increments nul_count, saturating at 255. It never affects the FIFO or err_overflow.
- Handshake: a byte transfers when out_valid and out_ready are both 1. While out_valid=1 and out_ready=0, out_char and out_valid hold stable. out_valid never drops without a transfer, except on clear or rst.
- FSM, all outputs registered:
  - IDLE: out_valid=0. If fifo_count>0, the next edge loads the head row char and moves to SEND_HI.
  - SEND_HI: out_char=row char. On transfer, move to SEND_LO with the column char.
  - SEND_LO: out_char=column char. On transfer, the head retires (pop). If another pair remains after the pop, move to SEND_HI with the next row char (no bubble); otherwise move to IDLE.
- Latency: a pair sampled at edge N with the FIFO empty and FSM in IDLE gives out_valid=1 with its row char after edge N+1.
- Throughput: with out_ready held high, one byte per cycle, i.e. one pair every 2 cycles. rst_cipher can present a pair every cycle, so the FIFO absorbs bursts of up to DEPTH pairs beyond the drain rate.
- fifo_count timing: incremented at a write edge and decremented at the SEND_LO transfer edge. A simultaneous write and pop leaves it unchanged.
- Pointers: wrap modulo DEPTH. Full and empty are derived from the count, not from pointer equality alone.
- Async rst mid-transfer: any in-flight byte and all buffered pairs are lost.

Decomposition:
- Shared package rst_cipher_pkg (shared with rst_cipher) holds:
  - NUL_CHAR = 8'h00;
  - typedef struct packed {logic [7:0] row; logic [7:0] col;} ctxt_pair_t;
  - typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} ser_state_t.
- One sub-module, rst_sync_fifo: parameterised width/depth synchronous FIFO with push, pop, clear, count, full and empty, plus the same async active-high reset. The serializer's top level holds the FSM, the drop/overflow logic and nul_count.

Test Plan:
- Single pair: after rst release, ctxt_str=16'h6162 ("ab") with ctxt_ready for 1 cycle, out_ready=1 → out_valid rises 2 edges later; bytes 8'h61 then 8'h62 on consecutive cycles; fifo_count goes 1→0; then IDLE.
- Back-pressure: push "ab", hold out_ready=0 for 5 cycles → out_char=8'h61 and out_valid=1 stable throughout. Release out_ready → 8'h61, 8'h62 transfer.
- Burst/overflow (DEPTH=8): 10 consecutive pairs "a0".."a9", out_ready=0 → fifo_count=8, err_overflow=1. Release out_ready → exactly the first 8 pairs drained in order. err_overflow stays 1 until a clear pulse sets it to 0.
- Full with retire: FIFO full, FSM in SEND_LO with out_ready=1, and ctxt_ready with a new pair in the same cycle → pair accepted, fifo_count stays 8, err_overflow stays 0.
- NUL handling: DROP_NUL=1, 3 pairs of 16'h0000 interleaved with "cd" → only 8'h63, 8'h64 emitted, nul_count=3. With 300 NULs → nul_count=255.
- Reset/clear mid-operation: 4 pairs buffered, rst asserted asynchronously between edges → outputs go to 0 immediately. Separately, clear together with ctxt_ready → FIFO empty, incoming pair discarded, out_valid=0 next cycle.
